uart_text_buffer: RTL and testbench

Character-cell text buffer sitting between the UART receiver (consumes received byte + new-data pulse) and the VGA text renderer (serves character codes by cell coordinate). Interprets printable ASCII and a small control-code set, maintains a write cursor with line wrap, and holds screen contents in an internal RAM. A sequential sweep engine blanks the whole screen after reset and on form-feed.

---
 rtl/uart_text_buffer.sv | 233 +++++++++++++++++++++++
 tb/tb_uart_text_buffer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_text_buffer.sv
// uart_text_buffer: character-cell screen store between the UART receiver and
// the VGA text renderer. Received bytes go through a one-entry pending slot,
// are interpreted (printable, CR/LF, backspace/DEL, form feed) and written at
// the cursor. A sweep engine blanks the whole screen after reset and on form
// feed. Optional macro TEXTBUF_ROW_CLEAR_EN blanks each row as the cursor
// enters it.
module uart_text_buffer #(
    parameter int         COLS  = 80,
    parameter int         ROWS  = 30,
    parameter int         COL_W = 7,
    parameter int         ROW_W = 5,
    parameter logic [6:0] BLANK = 7'h20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       rx_data,
    input  logic             rx_valid,
    input  logic [COL_W-1:0] rd_col,
    input  logic [ROW_W-1:0] rd_row,
    output logic [6:0]       rd_char,
    output logic [COL_W-1:0] cur_col,
    output logic [ROW_W-1:0] cur_row,
    output logic             busy,
    output logic             overflow
);

    localparam int               DEPTH     = ROWS * COLS;
    localparam int               AW        = $clog2(DEPTH);
    localparam logic [AW-1:0]    LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ROWS - 1);

    typedef enum logic [1:0] {
        ST_CLEAR  = 2'd0,
`ifdef TEXTBUF_ROW_CLEAR_EN
        ST_ROWCLR = 2'd2,
`endif
        ST_IDLE   = 2'd1
    } state_t;

    // Linear cell address; callers only pass in-range coordinates.
    function automatic logic [AW-1:0] addr_of(input logic [ROW_W-1:0] row,
                                              input logic [COL_W-1:0] col);
        return AW'(row) * AW'(COLS) + AW'(col);
    endfunction

    logic [6:0]       mem_r [0:DEPTH-1];
    state_t           state_r;
    logic [AW-1:0]    sweep_addr_r;
    logic             slot_full_r;
    logic [6:0]       slot_data_r;
`ifdef TEXTBUF_ROW_CLEAR_EN
    logic [COL_W-1:0] rc_col_r;
`endif

    logic             is_print_s;
    logic             is_nl_s;
    logic             is_bs_s;
    logic             is_ff_s;
    logic             consume_s;
    logic [ROW_W-1:0] next_row_s;
    logic [COL_W-1:0] bs_col_s;
    logic [ROW_W-1:0] bs_row_s;
    logic             rd_oob_s;
    logic [AW-1:0]    raddr_s;
    logic             we_s;
    logic [AW-1:0]    waddr_s;
    logic [6:0]       wdata_s;

    // Decode the pending byte and precompute cursor movement targets.
    always_comb begin
        is_print_s = (slot_data_r >= 7'h20) && (slot_data_r <= 7'h7E);
        is_nl_s    = (slot_data_r == 7'h0D) || (slot_data_r == 7'h0A);
        is_bs_s    = (slot_data_r == 7'h08) || (slot_data_r == 7'h7F);
        is_ff_s    = (slot_data_r == 7'h0C);
        consume_s  = slot_full_r && (state_r == ST_IDLE);
        next_row_s = (cur_row == ROW_LAST) ? {ROW_W{1'b0}} : cur_row + ROW_W'(1);
        if (cur_col != {COL_W{1'b0}}) begin
            bs_col_s = cur_col - COL_W'(1);
            bs_row_s = cur_row;
        end else if (cur_row != {ROW_W{1'b0}}) begin
            bs_col_s = COL_LAST;
            bs_row_s = cur_row - ROW_W'(1);
        end else begin
            bs_col_s = {COL_W{1'b0}};
            bs_row_s = {ROW_W{1'b0}};
        end
        rd_oob_s = (rd_col > COL_LAST) || (rd_row > ROW_LAST);
        raddr_s  = addr_of(rd_row, rd_col);
    end

    // Single RAM write port: sweep, row clear, printable store or backspace blank.
    always_comb begin
        we_s    = 1'b0;
        waddr_s = sweep_addr_r;
        wdata_s = BLANK;
        case (state_r)
            ST_CLEAR: begin
                we_s = 1'b1;
            end
            ST_IDLE: begin
                if (slot_full_r && is_print_s) begin
                    we_s    = 1'b1;
                    waddr_s = addr_of(cur_row, cur_col);
                    wdata_s = slot_data_r;
                end else if (slot_full_r && is_bs_s) begin
                    we_s    = 1'b1;
                    waddr_s = addr_of(bs_row_s, bs_col_s);
                end else begin
                    we_s = 1'b0;
                end
            end
`ifdef TEXTBUF_ROW_CLEAR_EN
            ST_ROWCLR: begin
                we_s    = 1'b1;
                waddr_s = addr_of(cur_row, rc_col_r);
            end
`endif
            default: begin
                we_s = 1'b0;
            end
        endcase
    end

    // Screen RAM write; no writes while reset is held.
    always_ff @(posedge clk) begin
        if (reset && we_s) begin
            mem_r[waddr_s] <= wdata_s;
        end
    end

    // Registered read port, read-before-write, blank for off-screen coordinates.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_char <= BLANK;
        end else if (rd_oob_s) begin
            rd_char <= BLANK;
        end else begin
            rd_char <= mem_r[raddr_s];
        end
    end

    // Control FSM: pending slot, cursor, clear sweep and status flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= ST_CLEAR;
            sweep_addr_r <= {AW{1'b0}};
            cur_col      <= {COL_W{1'b0}};
            cur_row      <= {ROW_W{1'b0}};
            busy         <= 1'b1;
            slot_full_r  <= 1'b0;
            slot_data_r  <= 7'h00;
            overflow     <= 1'b0;
`ifdef TEXTBUF_ROW_CLEAR_EN
            rc_col_r     <= {COL_W{1'b0}};
`endif
        end else begin
            // A byte arriving while the slot is full and not draining is lost.
            if (rx_valid) begin
                if (!slot_full_r || consume_s) begin
                    slot_full_r <= 1'b1;
                    slot_data_r <= rx_data;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (consume_s) begin
                slot_full_r <= 1'b0;
            end

            case (state_r)
                ST_CLEAR: begin
                    if (sweep_addr_r == LAST_ADDR) begin
                        state_r      <= ST_IDLE;
                        busy         <= 1'b0;
                        sweep_addr_r <= {AW{1'b0}};
                    end else begin
                        sweep_addr_r <= sweep_addr_r + AW'(1);
                    end
                end
                ST_IDLE: begin
                    if (slot_full_r) begin
                        if (is_print_s) begin
                            if (cur_col == COL_LAST) begin
                                cur_col <= {COL_W{1'b0}};
                                cur_row <= next_row_s;
`ifdef TEXTBUF_ROW_CLEAR_EN
                                state_r  <= ST_ROWCLR;
                                busy     <= 1'b1;
                                rc_col_r <= {COL_W{1'b0}};
`endif
                            end else begin
                                cur_col <= cur_col + COL_W'(1);
                            end
                        end else if (is_nl_s) begin
                            cur_col <= {COL_W{1'b0}};
                            cur_row <= next_row_s;
`ifdef TEXTBUF_ROW_CLEAR_EN
                            state_r  <= ST_ROWCLR;
                            busy     <= 1'b1;
                            rc_col_r <= {COL_W{1'b0}};
`endif
                        end else if (is_bs_s) begin
                            cur_col <= bs_col_s;
                            cur_row <= bs_row_s;
                        end else if (is_ff_s) begin
                            cur_col      <= {COL_W{1'b0}};
                            cur_row      <= {ROW_W{1'b0}};
                            state_r      <= ST_CLEAR;
                            sweep_addr_r <= {AW{1'b0}};
                            busy         <= 1'b1;
                        end
                    end
                end
`ifdef TEXTBUF_ROW_CLEAR_EN
                ST_ROWCLR: begin
                    if (rc_col_r == COL_LAST) begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        rc_col_r <= rc_col_r + COL_W'(1);
                    end
                end
`endif
                default: begin
                    state_r      <= ST_CLEAR;
                    sweep_addr_r <= {AW{1'b0}};
                    busy         <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_text_buffer.sv
// Directed testbench for uart_text_buffer (default 80x30 geometry).
module tb_uart_text_buffer;

    localparam int LIMIT = 5000;
`ifdef TEXTBUF_ROW_CLEAR_EN
    localparam bit ROWCLR = 1'b1;
`else
    localparam bit ROWCLR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] rx_data;
    logic       rx_valid;
    logic [6:0] rd_col;
    logic [4:0] rd_row;
    logic [6:0] rd_char;
    logic [6:0] cur_col;
    logic [4:0] cur_row;
    logic       busy;
    logic       overflow;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    uart_text_buffer dut (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rd_col   (rd_col),
        .rd_row   (rd_row),
        .rd_char  (rd_char),
        .cur_col  (cur_col),
        .cur_row  (cur_row),
        .busy     (busy),
        .overflow (overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [6:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy === 1'b1 && cyc < LIMIT) begin
            tick();
            cyc++;
        end
        n_checks++;
        if (busy !== 1'b0) $display("FAIL busy_timeout: busy=%b after %0d cycles, required 0", busy, cyc);
        else n_pass++;
    endtask

    task automatic put(input logic [6:0] b);
        int c;
        pulse(b);
        tick();
        wait_idle(c);
    endtask

    task automatic rd(input logic [6:0] c, input logic [4:0] r, output logic [6:0] v);
        rd_col = c;
        rd_row = r;
        tick();
        v = rd_char;
    endtask

    task automatic test_reset();
        int cyc;
        logic [6:0] v;
        reset = 1'b0; rx_valid = 1'b0; rx_data = 7'h00; rd_col = 7'd0; rd_row = 5'd0;
        tick(); tick();
        n_checks++; if (busy !== 1'b1) $display("FAIL reset_busy: got %b need 1", busy); else n_pass++;
        n_checks++; if (cur_col !== 7'd0 || cur_row !== 5'd0) $display("FAIL reset_cursor: got (%0d,%0d) need (0,0)", cur_col, cur_row); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b need 0", overflow); else n_pass++;
        n_checks++; if (rd_char !== 7'h20) $display("FAIL reset_rd_char: got %h need 20", rd_char); else n_pass++;
        reset = 1'b1;
        wait_idle(cyc);
        n_checks++; if (cyc !== 2400) $display("FAIL clear_length: busy cycles %0d need 2400", cyc); else n_pass++;
        rd(7'd0, 5'd0, v);
        n_checks++; if (v !== 7'h20) $display("FAIL clear_0_0: got %h need 20", v); else n_pass++;
        rd(7'd79, 5'd29, v);
        n_checks++; if (v !== 7'h20) $display("FAIL clear_79_29: got %h need 20", v); else n_pass++;
        rd(7'd40, 5'd15, v);
        n_checks++; if (v !== 7'h20) $display("FAIL clear_40_15: got %h need 20", v); else n_pass++;
        n_checks++; if (cur_col !== 7'd0 || cur_row !== 5'd0 || overflow !== 1'b0) $display("FAIL post_clear_state: cursor (%0d,%0d) ovf %b need (0,0) 0", cur_col, cur_row, overflow); else n_pass++;
    endtask

    task automatic test_single();
        logic [6:0] v;
        pulse(7'h41);
        n_checks++; if (cur_col !== 7'd0) $display("FAIL single_slot_latency: col %0d need 0", cur_col); else n_pass++;
        tick();
        n_checks++; if (cur_col !== 7'd1 || cur_row !== 5'd0) $display("FAIL single_cursor: got (%0d,%0d) need (1,0)", cur_col, cur_row); else n_pass++;
        rd(7'd0, 5'd0, v);
        n_checks++; if (v !== 7'h41) $display("FAIL single_cell: got %h need 41", v); else n_pass++;
    endtask

    task automatic test_row_wrap();
        logic [6:0] v;
        logic [6:0] e;
        put(7'h0C);
        n_checks++; if (cur_col !== 7'd0 || cur_row !== 5'd0) $display("FAIL ff_home: got (%0d,%0d) need (0,0)", cur_col, cur_row); else n_pass++;
        for (int i = 0; i < 80; i++) put(7'h21 + 7'(i));
        n_checks++; if (cur_col !== 7'd0 || cur_row !== 5'd1) $display("FAIL wrap_cursor: got (%0d,%0d) need (0,1)", cur_col, cur_row); else n_pass++;
        for (int i = 0; i < 80; i++) begin
            e = 7'h21 + 7'(i);
            rd(7'(i), 5'd0, v);
            n_checks++; if (v !== e) $display("FAIL row0_cell_%0d: got %h need %h", i, v, e); else n_pass++;
        end
        put(7'h08);
        n_checks++; if (cur_col !== 7'd79 || cur_row !== 5'd0) $display("FAIL bs_row_back: got (%0d,%0d) need (79,0)", cur_col, cur_row); else n_pass++;
        rd(7'd79, 5'd0, v);
        n_checks++; if (v !== 7'h20) $display("FAIL bs_blank_79_0: got %h need 20", v); else n_pass++;
    endtask

    task automatic test_corner();
        logic [6:0] v;
        logic [6:0] e;
        for (int i = 0; i < 29; i++) put(7'h0A);
        n_checks++; if (cur_col !== 7'd0 || cur_row !== 5'd29) $display("FAIL lf_to_last: got (%0d,%0d) need (0,29)", cur_col, cur_row); else n_pass++;
        for (int i = 0; i < 79; i++) put(7'h62);
        n_checks++; if (cur_col !== 7'd79 || cur_row !== 5'd29) $display("FAIL reach_corner: got (%0d,%0d) need (79,29)", cur_col, cur_row); else n_pass++;
        put(7'h5A);
        n_checks++; if (cur_col !== 7'd0 || cur_row !== 5'd0) $display("FAIL corner_wrap: got (%0d,%0d) need (0,0)", cur_col, cur_row); else n_pass++;
        rd(7'd79, 5'd29, v);
        n_checks++; if (v !== 7'h5A) $display("FAIL corner_cell: got %h need 5a", v); else n_pass++;
        rd(7'd78, 5'd29, v);
        n_checks++; if (v !== 7'h62) $display("FAIL corner_prev_cell: got %h need 62", v); else n_pass++;
        for (int i = 0; i < 29; i++) put(7'h0A);
        for (int i = 0; i < 5; i++) put(7'h63);
        n_checks++; if (cur_col !== 7'd5 || cur_row !== 5'd29) $display("FAIL reach_5_29: got (%0d,%0d) need (5,29)", cur_col, cur_row); else n_pass++;
        put(7'h0A);
        n_checks++; if (cur_col !== 7'd0 || cur_row !== 5'd0) $display("FAIL lf_last_row_wrap: got (%0d,%0d) need (0,0)", cur_col, cur_row); else n_pass++;
        e = ROWCLR ? 7'h20 : 7'h21;
        rd(7'd0, 5'd0, v);
        n_checks++; if (v !== e) $display("FAIL origin_before_bs: got %h need %h", v, e); else n_pass++;
        put(7'h08);
        n_checks++; if (cur_col !== 7'd0 || cur_row !== 5'd0) $display("FAIL bs_at_origin: got (%0d,%0d) need (0,0)", cur_col, cur_row); else n_pass++;
        rd(7'd0, 5'd0, v);
        n_checks++; if (v !== 7'h20) $display("FAIL bs_origin_blank: got %h need 20", v); else n_pass++;
        put(7'h41);
        put(7'h07);
        n_checks++; if (cur_col !== 7'd1 || cur_row !== 5'd0) $display("FAIL discard_ctrl: got (%0d,%0d) need (1,0)", cur_col, cur_row); else n_pass++;
        e = ROWCLR ? 7'h20 : 7'h22;
        rd(7'd1, 5'd0, v);
        n_checks++; if (v !== e) $display("FAIL discard_no_write: got %h need %h", v, e); else n_pass++;
        put(7'h7F);
        n_checks++; if (cur_col !== 7'd0 || cur_row !== 5'd0) $display("FAIL del_cursor: got (%0d,%0d) need (0,0)", cur_col, cur_row); else n_pass++;
        rd(7'd0, 5'd0, v);
        n_checks++; if (v !== 7'h20) $display("FAIL del_blank: got %h need 20", v); else n_pass++;
    endtask

    task automatic test_overflow();
        int cyc;
        logic [6:0] v;
        pulse(7'h0C);
        tick();
        n_checks++; if (busy !== 1'b1) $display("FAIL ff_busy: got %b need 1", busy); else n_pass++;
        pulse(7'h31);
        n_checks++; if (overflow !== 1'b0) $display("FAIL ovf_first_byte: got %b need 0", overflow); else n_pass++;
        pulse(7'h32);
        n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_second_byte: got %b need 1", overflow); else n_pass++;
        wait_idle(cyc);
        tick();
        n_checks++; if (cur_col !== 7'd1 || cur_row !== 5'd0) $display("FAIL held_byte_cursor: got (%0d,%0d) need (1,0)", cur_col, cur_row); else n_pass++;
        rd(7'd0, 5'd0, v);
        n_checks++; if (v !== 7'h31) $display("FAIL held_byte_cell: got %h need 31", v); else n_pass++;
        rd(7'd1, 5'd0, v);
        n_checks++; if (v !== 7'h20) $display("FAIL dropped_byte_cell: got %h need 20", v); else n_pass++;
        rd(7'd0, 5'd30, v);
        n_checks++; if (v !== 7'h20) $display("FAIL oob_row_read: got %h need 20", v); else n_pass++;
        rd(7'd80, 5'd0, v);
        n_checks++; if (v !== 7'h20) $display("FAIL oob_col_read: got %h need 20", v); else n_pass++;
        n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b need 1", overflow); else n_pass++;
    endtask

    task automatic test_reset_mid_sweep();
        int cyc;
        logic [6:0] v;
        reset = 1'b0;
        tick(); tick();
        reset = 1'b1;
        repeat (100) tick();
        n_checks++; if (busy !== 1'b1) $display("FAIL mid_sweep_busy: got %b need 1", busy); else n_pass++;
        reset = 1'b0;
        tick();
        n_checks++; if (overflow !== 1'b0 || cur_col !== 7'd0) $display("FAIL mid_reset_state: ovf %b col %0d need 0 0", overflow, cur_col); else n_pass++;
        reset = 1'b1;
        wait_idle(cyc);
        n_checks++; if (cyc !== 2400) $display("FAIL restart_length: busy cycles %0d need 2400", cyc); else n_pass++;
        rd(7'd0, 5'd0, v);
        n_checks++; if (v !== 7'h20) $display("FAIL restart_cleared: got %h need 20", v); else n_pass++;
    endtask

`ifdef TEXTBUF_ROW_CLEAR_EN
    task automatic test_row_clear();
        int cyc;
        logic [6:0] v;
        for (int i = 0; i < 4; i++) put(7'h0A);
        for (int i = 0; i < 3; i++) put(7'h58);
        for (int i = 0; i < 29; i++) put(7'h0A);
        n_checks++; if (cur_col !== 7'd0 || cur_row !== 5'd3) $display("FAIL rc_reach_row3: got (%0d,%0d) need (0,3)", cur_col, cur_row); else n_pass++;
        rd(7'd1, 5'd4, v);
        n_checks++; if (v !== 7'h58) $display("FAIL rc_row4_before: got %h need 58", v); else n_pass++;
        pulse(7'h0D);
        tick();
        wait_idle(cyc);
        n_checks++; if (cyc !== 80) $display("FAIL rc_busy_length: busy cycles %0d need 80", cyc); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            rd(7'(i), 5'd4, v);
            n_checks++; if (v !== 7'h20) $display("FAIL rc_row4_cell_%0d: got %h need 20", i, v); else n_pass++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_row_wrap();
        test_corner();
        test_overflow();
        test_reset_mid_sweep();
`ifdef TEXTBUF_ROW_CLEAR_EN
        test_row_clear();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
